dmem_dual_issue_arbiter: RTL and testbench

//  Shares the single data-memory port between the two execute slots of the dual-issue rv32i_cpu.

---
 rtl/dmem_dual_issue_arbiter_if.sv | 50 +++++
 rtl/dmem_dual_issue_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_dual_issue_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dual_issue_arbiter_if.sv
// Purpose : bundles the two execute-slot requests, the data-memory port and the load response.
// Latency : none (signal bundle only).
// Backpress: stall is the only backpressure; it holds the front end for one cycle per conflict.
// Ports   : slave = arbiter side, master = CPU/memory side.
interface dmem_dual_issue_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Slot requests
    logic            req0_re;
    logic [3:0]      req0_we;
    logic [XLEN-1:0] req0_addr;
    logic [XLEN-1:0] req0_wdata;
    logic [4:0]      req0_rd;
    logic            req1_re;
    logic [3:0]      req1_we;
    logic [XLEN-1:0] req1_addr;
    logic [XLEN-1:0] req1_wdata;
    logic [4:0]      req1_rd;
    // Front-end hold
    logic            stall;
    // Memory port
    logic [XLEN-1:0] data_addr;
    logic [XLEN-1:0] data_wdata;
    logic [3:0]      data_we;
    logic            data_re;
    logic [XLEN-1:0] data_rdata;
    // Load response
    logic            resp_valid;
    logic            resp_slot;
    logic [4:0]      resp_rd;
    logic [XLEN-1:0] resp_data;
    logic [CNT_W-1:0] conflict_cnt;

    modport slave (
        input  req0_re, req0_we, req0_addr, req0_wdata, req0_rd,
        input  req1_re, req1_we, req1_addr, req1_wdata, req1_rd,
        input  data_rdata,
        output stall, data_addr, data_wdata, data_we, data_re,
        output resp_valid, resp_slot, resp_rd, resp_data, conflict_cnt
    );

    modport master (
        output req0_re, req0_we, req0_addr, req0_wdata, req0_rd,
        output req1_re, req1_we, req1_addr, req1_wdata, req1_rd,
        output data_rdata,
        input  stall, data_addr, data_wdata, data_we, data_re,
        input  resp_valid, resp_slot, resp_rd, resp_data, conflict_cnt
    );
endinterface

// File: rtl/dmem_dual_issue_arbiter.sv
// Purpose : shares one data-memory port between two issue slots; slot0 (older) wins, slot1 is deferred.
// Latency : memory port driven same cycle (combinational); load response one cycle after issue.
// Backpress: stall=1 for exactly one cycle when both slots access memory together.
// Ports   : clk, rst (sync, active-high), bus (slave modport: requests, memory port, response, counter).
module dmem_dual_issue_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    dmem_dual_issue_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic             hold_re;
    logic [3:0]       hold_we;
    logic [XLEN-1:0]  hold_addr;
    logic [XLEN-1:0]  hold_wdata;
    logic [4:0]       hold_rd;
    logic [CNT_W-1:0] cnt;
    logic             pipe_vld;
    logic             pipe_slot;
    logic [4:0]       pipe_rd;

    logic             act0;
    logic             act1;
    logic             ld0;
    logic             ld1;
    logic             port_re;
    logic [3:0]       port_we;
    logic [XLEN-1:0]  port_addr;
    logic [XLEN-1:0]  port_wdata;
    logic             port_stall;
    logic             sel_slot;
    logic [4:0]       sel_rd;

    // A store with re also set is a store: the read is dropped.
    assign act0 = bus.req0_re | (|bus.req0_we);
    assign act1 = bus.req1_re | (|bus.req1_we);
    assign ld0  = bus.req0_re & (bus.req0_we == 4'h0);
    assign ld1  = bus.req1_re & (bus.req1_we == 4'h0);

    // Port mux. Gated by rst so that nothing (including a held store) reaches
    // memory in the reset cycle and no load issued then gets a response.
    always_comb begin
        port_re    = 1'b0;
        port_we    = 4'h0;
        port_addr  = '0;
        port_wdata = '0;
        port_stall = 1'b0;
        sel_slot   = 1'b0;
        sel_rd     = 5'd0;
        if (!rst) begin
            if (state == HOLD) begin
                port_re    = hold_re;
                port_we    = hold_we;
                port_addr  = hold_addr;
                port_wdata = hold_wdata;
                sel_slot   = 1'b1;
                sel_rd     = hold_rd;
            end else if (act0) begin
                port_re    = ld0;
                port_we    = bus.req0_we;
                port_addr  = bus.req0_addr;
                port_wdata = bus.req0_wdata;
                port_stall = act1;
                sel_slot   = 1'b0;
                sel_rd     = bus.req0_rd;
            end else if (act1) begin
                port_re    = ld1;
                port_we    = bus.req1_we;
                port_addr  = bus.req1_addr;
                port_wdata = bus.req1_wdata;
                sel_slot   = 1'b1;
                sel_rd     = bus.req1_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_re    <= 1'b0;
            hold_we    <= 4'h0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_rd    <= 5'd0;
            cnt        <= '0;
            pipe_vld   <= 1'b0;
            pipe_slot  <= 1'b0;
            pipe_rd    <= 5'd0;
        end else begin
            // Response tag follows the load that used the port this cycle.
            pipe_vld  <= port_re;
            pipe_slot <= port_re ? sel_slot : 1'b0;
            pipe_rd   <= port_re ? sel_rd : 5'd0;
            if (state == IDLE) begin
                if (act0 && act1) begin
                    state      <= HOLD;
                    hold_re    <= ld1;
                    hold_we    <= bus.req1_we;
                    hold_addr  <= bus.req1_addr;
                    hold_wdata <= bus.req1_wdata;
                    hold_rd    <= bus.req1_rd;
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end else begin
                // Slot1 replays exactly once; req inputs are ignored here.
                state   <= IDLE;
                hold_re <= 1'b0;
                hold_we <= 4'h0;
            end
        end
    end

    assign bus.stall        = port_stall;
    assign bus.data_re      = port_re;
    assign bus.data_we      = port_we;
    assign bus.data_addr    = port_addr;
    assign bus.data_wdata   = port_wdata;
    assign bus.resp_valid   = pipe_vld;
    assign bus.resp_slot    = pipe_slot;
    assign bus.resp_rd      = pipe_rd;
    assign bus.resp_data    = pipe_vld ? bus.data_rdata : '0;
    assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_dmem_dual_issue_arbiter.sv
// Purpose : directed table-driven bench for dmem_dual_issue_arbiter with a word memory model.
// Latency : inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpress: stall must never be high on two consecutive cycles.
module tb_dmem_dual_issue_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_dual_issue_arbiter_if #(.XLEN(32), .CNT_W(16)) bus ();
    dmem_dual_issue_arbiter_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    dmem_dual_issue_arbiter #(.XLEN(32), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    dmem_dual_issue_arbiter #(.XLEN(32), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Second instance sees the same requests; only its counter is checked.
    assign bus2.req0_re    = bus.req0_re;
    assign bus2.req0_we    = bus.req0_we;
    assign bus2.req0_addr  = bus.req0_addr;
    assign bus2.req0_wdata = bus.req0_wdata;
    assign bus2.req0_rd    = bus.req0_rd;
    assign bus2.req1_re    = bus.req1_re;
    assign bus2.req1_we    = bus.req1_we;
    assign bus2.req1_addr  = bus.req1_addr;
    assign bus2.req1_wdata = bus.req1_wdata;
    assign bus2.req1_rd    = bus.req1_rd;
    assign bus2.data_rdata = 32'h0;

    // Memory model: synchronous read, byte-enabled write.
    logic [31:0] mem [0:255];
    logic [31:0] rdata_q = 32'h0;
    assign bus.data_rdata = rdata_q;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.data_we[b]) mem[bus.data_addr[9:2]][8*b +: 8] <= bus.data_wdata[8*b +: 8];
        end
        if (bus.data_re) rdata_q <= mem[bus.data_addr[9:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus.stall) chk("stall_2cyc", {31'd0, prev_stall}, 32'd0);
        prev_stall <= bus.stall;
    end

    typedef struct {
        logic        re0; logic [3:0] we0; logic [31:0] a0; logic [31:0] wd0; logic [4:0] rd0;
        logic        re1; logic [3:0] we1; logic [31:0] a1; logic [31:0] wd1; logic [4:0] rd1;
        logic        stall; logic dre; logic [3:0] dwe; logic [31:0] addr; logic [31:0] wd;
        logic        rv; logic rslot; logic [4:0] rrd; logic [31:0] rdata; logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic re0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] wd0, input logic [4:0] rd0,
        input logic re1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] wd1, input logic [4:0] rd1,
        input logic st, input logic dre, input logic [3:0] dwe, input logic [31:0] addr, input logic [31:0] wd,
        input logic rv, input logic rslot, input logic [4:0] rrd, input logic [31:0] rdata, input logic [15:0] cnt);
        vec_t v;
        v.re0 = re0; v.we0 = we0; v.a0 = a0; v.wd0 = wd0; v.rd0 = rd0;
        v.re1 = re1; v.we1 = we1; v.a1 = a1; v.wd1 = wd1; v.rd1 = rd1;
        v.stall = st; v.dre = dre; v.dwe = dwe; v.addr = addr; v.wd = wd;
        v.rv = rv; v.rslot = rslot; v.rrd = rrd; v.rdata = rdata; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive(input logic re0, input logic [3:0] we0, input logic [31:0] a0, input logic [31:0] wd0, input logic [4:0] rd0,
                         input logic re1, input logic [3:0] we1, input logic [31:0] a1, input logic [31:0] wd1, input logic [4:0] rd1);
        bus.req0_re = re0; bus.req0_we = we0; bus.req0_addr = a0; bus.req0_wdata = wd0; bus.req0_rd = rd0;
        bus.req1_re = re1; bus.req1_we = we1; bus.req1_addr = a1; bus.req1_wdata = wd1; bus.req1_rd = rd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[64] = 32'h1111_2222;   // 0x100
        mem[4]  = 32'h3333_4444;   // 0x10

        //        re0 we0  a0      wd0           rd0 re1 we1  a1      wd1           rd1 | st dre dwe  addr    wd            rv sl rrd  rdata          cnt
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        0, 0, 0,  32'h0,         0));
        tbl.push_back(mk(1, 4'h0, 32'h100, 32'h0,        5, 0, 4'h0, 32'h000, 32'h0,        0,  0, 1, 4'h0, 32'h100, 32'h0,        0, 0, 0,  32'h0,         0));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        1, 0, 5,  32'h1111_2222, 0));
        tbl.push_back(mk(0, 4'hF, 32'h200, 32'hAABBCCDD, 0, 1, 4'h0, 32'h200, 32'h0,        7,  1, 0, 4'hF, 32'h200, 32'hAABBCCDD, 0, 0, 0,  32'h0,         0));
        tbl.push_back(mk(0, 4'hF, 32'h200, 32'hAABBCCDD, 0, 1, 4'h0, 32'h200, 32'h0,        7,  0, 1, 4'h0, 32'h200, 32'h0,        0, 0, 0,  32'h0,         1));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        1, 1, 7,  32'hAABBCCDD, 1));
        tbl.push_back(mk(1, 4'h0, 32'h010, 32'h0,        3, 0, 4'hF, 32'h010, 32'h1,        0,  1, 1, 4'h0, 32'h010, 32'h0,        0, 0, 0,  32'h0,         1));
        tbl.push_back(mk(1, 4'h0, 32'h010, 32'h0,        3, 0, 4'hF, 32'h010, 32'h1,        0,  0, 0, 4'hF, 32'h010, 32'h1,        1, 0, 3,  32'h3333_4444, 2));
        tbl.push_back(mk(1, 4'h0, 32'h010, 32'h0,        4, 0, 4'h0, 32'h000, 32'h0,        0,  0, 1, 4'h0, 32'h010, 32'h0,        0, 0, 0,  32'h0,         2));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        1, 0, 4,  32'h1,         2));
        tbl.push_back(mk(1, 4'h0, 32'h040, 32'h0,        8, 1, 4'h0, 32'h044, 32'h0,       12,  1, 1, 4'h0, 32'h040, 32'h0,        0, 0, 0,  32'h0,         2));
        tbl.push_back(mk(1, 4'h0, 32'h040, 32'h0,        8, 1, 4'h0, 32'h044, 32'h0,       12,  0, 1, 4'h0, 32'h044, 32'h0,        1, 0, 8,  32'hC0DE_0010, 3));
        tbl.push_back(mk(1, 4'h0, 32'h048, 32'h0,        9, 1, 4'h0, 32'h04C, 32'h0,       13,  1, 1, 4'h0, 32'h048, 32'h0,        1, 1, 12, 32'hC0DE_0011, 3));
        tbl.push_back(mk(1, 4'h0, 32'h048, 32'h0,        9, 1, 4'h0, 32'h04C, 32'h0,       13,  0, 1, 4'h0, 32'h04C, 32'h0,        1, 0, 9,  32'hC0DE_0012, 4));
        tbl.push_back(mk(1, 4'h0, 32'h050, 32'h0,       10, 1, 4'h0, 32'h054, 32'h0,       14,  1, 1, 4'h0, 32'h050, 32'h0,        1, 1, 13, 32'hC0DE_0013, 4));
        tbl.push_back(mk(1, 4'h0, 32'h050, 32'h0,       10, 1, 4'h0, 32'h054, 32'h0,       14,  0, 1, 4'h0, 32'h054, 32'h0,        1, 0, 10, 32'hC0DE_0014, 5));
        tbl.push_back(mk(1, 4'h0, 32'h058, 32'h0,       11, 1, 4'h0, 32'h05C, 32'h0,       15,  1, 1, 4'h0, 32'h058, 32'h0,        1, 1, 14, 32'hC0DE_0015, 5));
        tbl.push_back(mk(1, 4'h0, 32'h058, 32'h0,       11, 1, 4'h0, 32'h05C, 32'h0,       15,  0, 1, 4'h0, 32'h05C, 32'h0,        1, 0, 11, 32'hC0DE_0016, 6));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        1, 1, 15, 32'hC0DE_0017, 6));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 1, 4'h3, 32'h060, 32'h12345678, 2,  0, 0, 4'h3, 32'h060, 32'h12345678, 0, 0, 0,  32'h0,         6));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 1, 4'h0, 32'h060, 32'h0,        2,  0, 1, 4'h0, 32'h060, 32'h0,        0, 0, 0,  32'h0,         6));
        tbl.push_back(mk(0, 4'h0, 32'h000, 32'h0,        0, 0, 4'h0, 32'h000, 32'h0,        0,  0, 0, 4'h0, 32'h000, 32'h0,        1, 1, 2,  32'hC0DE_5678, 6));

        // Reset state
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_re", {31'd0, bus.data_re}, 32'd0);
        chk("rst_we", {28'd0, bus.data_we}, 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_wdata", bus.data_wdata, 32'd0);
        chk("rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_rslot", {31'd0, bus.resp_slot}, 32'd0);
        chk("rst_rrd", {27'd0, bus.resp_rd}, 32'd0);
        chk("rst_rdata", bus.resp_data, 32'd0);
        chk("rst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Table: single load, store-before-load, load-before-store, 4 pairs, masked re on a store
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].re0, tbl[i].we0, tbl[i].a0, tbl[i].wd0, tbl[i].rd0,
                  tbl[i].re1, tbl[i].we1, tbl[i].a1, tbl[i].wd1, tbl[i].rd1);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].stall});
            chk($sformatf("v%0d_re", i), {31'd0, bus.data_re}, {31'd0, tbl[i].dre});
            chk($sformatf("v%0d_we", i), {28'd0, bus.data_we}, {28'd0, tbl[i].dwe});
            chk($sformatf("v%0d_addr", i), bus.data_addr, tbl[i].addr);
            chk($sformatf("v%0d_wdata", i), bus.data_wdata, tbl[i].wd);
            chk($sformatf("v%0d_rvalid", i), {31'd0, bus.resp_valid}, {31'd0, tbl[i].rv});
            chk($sformatf("v%0d_rslot", i), {31'd0, bus.resp_slot}, {31'd0, tbl[i].rslot});
            chk($sformatf("v%0d_rrd", i), {27'd0, bus.resp_rd}, {27'd0, tbl[i].rrd});
            chk($sformatf("v%0d_rdata", i), bus.resp_data, tbl[i].rdata);
            chk($sformatf("v%0d_cnt", i), {16'd0, bus.conflict_cnt}, {16'd0, tbl[i].cnt});
            next_cycle();
        end

        // Reset during HOLD: held slot1 store to 0x74 must never land
        drive(1, 4'h0, 32'h070, 32'h0, 1, 0, 4'hF, 32'h074, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("hr_pair_stall", {31'd0, bus.stall}, 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("hr_rstcyc_we", {28'd0, bus.data_we}, 32'd0);
        chk("hr_rstcyc_stall", {31'd0, bus.stall}, 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("hr_stall", {31'd0, bus.stall}, 32'd0);
        chk("hr_re", {31'd0, bus.data_re}, 32'd0);
        chk("hr_we", {28'd0, bus.data_we}, 32'd0);
        chk("hr_rvalid", {31'd0, bus.resp_valid}, 32'd0);
        chk("hr_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
        chk("hr_cnt2", {30'd0, bus2.conflict_cnt}, 32'd0);
        next_cycle();
        drive(1, 4'h0, 32'h074, 32'h0, 6, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("hr_rd_re", {31'd0, bus.data_re}, 32'd1);
        next_cycle();
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("hr_rd_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("hr_rd_rd", {27'd0, bus.resp_rd}, 32'd6);
        chk("hr_rd_data", bus.resp_data, 32'hC0DE_001D);
        next_cycle();

        // Saturation: 5 conflicts, 2-bit counter stops at 3
        for (int k = 0; k < 5; k++) begin
            drive(1, 4'h0, 32'h080, 32'h0, 1, 1, 4'h0, 32'h084, 32'h0, 2);
            @(negedge clk);
            chk($sformatf("sat%0d_stall", k), {31'd0, bus.stall}, 32'd1);
            next_cycle();
            @(negedge clk);
            chk($sformatf("sat%0d_cnt", k), {16'd0, bus.conflict_cnt}, k + 1);
            chk($sformatf("sat%0d_cnt2", k), {30'd0, bus2.conflict_cnt}, (k + 1 > 3) ? 3 : k + 1);
            next_cycle();
        end
        drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
